// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU sharing logic.
//   - ALU_* : 4-bit ALU operation codes as seen on alu_op.
//   - state_t : sequencer states of the arbiter (IDLE, EXEC, RESP).
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_PASS = 4'b0010;
    localparam logic [3:0] ALU_NOT  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_NAND = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_XNOR = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRL  = 4'b1011;
    localparam logic [3:0] ALU_ASL1 = 4'b1100;
    localparam logic [3:0] ALU_ASR1 = 4'b1101;
    localparam logic [3:0] ALU_NEG  = 4'b1110;
    localparam logic [3:0] ALU_ZERO = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req       : request bits, one per requester
//   last      : index of the most recently granted requester
//   grant     : one-hot grant (all zero when nothing requests)
//   grant_idx : index of the granted requester
//   any       : high when some request is present
// The scan starts at last+1 (mod NREQ), so the previous winner has the
// lowest priority on the next decision.
module rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    int cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last) + k) % NREQ;
            if (!any && req[cand[IW-1:0]]) begin
                any                = 1'b1;
                grant[cand[IW-1:0]] = 1'b1;
                grant_idx          = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between NREQ requesters.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester request channel
//   req_op/req_a/req_b    : per-requester op and operands (packed slices)
//   rsp_valid/rsp_ready   : per-requester response channel (one-hot valid)
//   rsp_result/rsp_bcond  : captured ALU result, shared by all requesters
//   alu_in_1/2, alu_op    : drive the ALU (idle value: zeros, ZERO op)
//   alu_result/alu_bcond  : ALU combinational outputs
//   busy                  : an operation is in flight
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready of the same requester are high. Request fields are sampled only on
// that edge; valid may drop beforehand without effect. A response is held
// (valid and data stable) until the owner's ready is high at an edge.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_result,
    output logic              rsp_bcond,
    output logic [W-1:0]      alu_in_1,
    output logic [W-1:0]      alu_in_2,
    output logic [3:0]        alu_op,
    input  logic [W-1:0]      alu_result,
    input  logic              alu_bcond,
    output logic              busy
);

    localparam int IW = $clog2(NREQ);

    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   owner;
    logic [3:0]      op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;

    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req       (req_valid),
        .last      (last),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // Ready goes only to the round-robin winner, and only while idle, so an
    // accepted request is exactly "IDLE and some request present".
    assign req_ready = (state == IDLE) ? pick_grant : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last       <= IW'(NREQ - 1);
            owner      <= '0;
            op_q       <= ALU_ZERO;
            a_q        <= '0;
            b_q        <= '0;
            rsp_result <= '0;
            rsp_bcond  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        op_q  <= req_op[4*int'(pick_idx) +: 4];
                        a_q   <= req_a[W*int'(pick_idx) +: W];
                        b_q   <= req_b[W*int'(pick_idx) +: W];
                        owner <= pick_idx;
                        last  <= pick_idx;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_bcond  <= alu_bcond;
                    state      <= RESP;
                end
                RESP: begin
                    // Only the owner's ready can close the response.
                    if (rsp_ready[owner]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The ALU sees the latched operands only during EXEC; otherwise it is
    // parked on the ZERO op with zero inputs.
    assign alu_in_1 = (state == EXEC) ? a_q  : '0;
    assign alu_in_2 = (state == EXEC) ? b_q  : '0;
    assign alu_op   = (state == EXEC) ? op_q : ALU_ZERO;

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 32;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_result;
  logic              rsp_bcond;
  logic [W-1:0]      alu_in_1;
  logic [W-1:0]      alu_in_2;
  logic [3:0]        alu_op;
  logic [W-1:0]      alu_result;
  logic              alu_bcond;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  // expected {bcond, result} of responses still to be seen
  logic [W:0] exp_q[$];

  alu_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_bcond  (rsp_bcond),
    .alu_in_1   (alu_in_1),
    .alu_in_2   (alu_in_2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_bcond  (alu_bcond),
    .busy       (busy)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- ALU behaviour ({bcond, result}) ----------------
  function automatic logic [W:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic bc;
    case (op)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a;
      4'b0011: r = ~a;
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = ~(a & b);
      4'b0111: r = ~(a | b);
      4'b1000: r = a ^ b;
      4'b1001: r = ~(a ^ b);
      4'b1010: r = a << b[4:0];
      4'b1011: r = a >> b[4:0];
      4'b1100: r = a << 1;
      4'b1101: r = W'($signed(a) >>> 1);
      4'b1110: r = -a;
      default: r = '0;
    endcase
    case (op)
      4'b0000: bc = (a == b);
      4'b1000: bc = (a < b);
      4'b1010: bc = (a != b);
      4'b1011: bc = (a >= b);
      default: bc = 1'b0;
    endcase
    return {bc, r};
  endfunction

  assign {alu_bcond, alu_result} = alu_ref(alu_op, alu_in_1, alu_in_2);

  // ---------------- reference model (transaction level) ----------------
  // phase: 0 free, 1 operation being computed, 2 response outstanding
  int         ref_phase = 0;
  int         ref_last  = NREQ - 1;
  int         ref_owner = 0;
  logic [3:0] ref_op    = 4'hF;
  logic [W-1:0] ref_a   = '0;
  logic [W-1:0] ref_b   = '0;
  logic [W-1:0] ref_res = '0;
  logic       ref_bc    = 1'b0;

  function automatic int ref_grant();
    if (ref_phase != 0) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (ref_last + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  // Advance one clock; the model follows the edge using the inputs applied now.
  task automatic step();
    int g;
    g = ref_grant();
    @(posedge clk);
    if (reset) begin
      ref_phase = 0;
      ref_last  = NREQ - 1;
      ref_res   = '0;
      ref_bc    = 1'b0;
    end else if (ref_phase == 0) begin
      if (g >= 0) begin
        ref_op    = req_op[4*g +: 4];
        ref_a     = req_a[W*g +: W];
        ref_b     = req_b[W*g +: W];
        ref_owner = g;
        ref_last  = g;
        ref_phase = 1;
      end
    end else if (ref_phase == 1) begin
      {ref_bc, ref_res} = alu_ref(ref_op, ref_a, ref_b);
      ref_phase = 2;
    end else begin
      if (rsp_ready[ref_owner]) ref_phase = 0;
    end
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[4*i +: 4] = op;
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 4'($urandom_range(0, 15)), $urandom, $urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = '0;
    req_op = '0; req_a = '0; req_b = '0;
    step(); step();
    reset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    n_checks++; if (alu_op !== 4'hF) begin n_fail++; $display("FAIL reset_alu_op: got %h want f", alu_op); end
    n_checks++; if (alu_in_1 !== '0 || alu_in_2 !== '0) begin n_fail++; $display("FAIL reset_alu_in: got %h/%h want 0/0", alu_in_1, alu_in_2); end
    n_checks++; if (rsp_result !== '0 || rsp_bcond !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_data: got %h/%b want 0/0", rsp_result, rsp_bcond); end
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL reset_priority: got %b want 01", req_ready); end
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_single();
    set_req(0, 4'b0000, 32'd5, 32'd7);
    req_valid = 2'b01; rsp_ready = 2'b00;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    set_req(0, 4'b0001, 32'd99, 32'd1);  // must not affect the captured op
    #1;
    n_checks++; if (alu_op !== 4'b0000 || alu_in_1 !== 32'd5 || alu_in_2 !== 32'd7) begin
      n_fail++; $display("FAIL single_exec: got op %h a %0d b %0d want op 0 a 5 b 7", alu_op, alu_in_1, alu_in_2); end
    n_checks++; if (busy !== 1'b1 || req_ready !== 2'b00) begin n_fail++; $display("FAIL single_exec_busy: got busy %b ready %b want 1/00", busy, req_ready); end
    step();
    n_checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd12 || rsp_bcond !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp: got v %b r %0d bc %b want 01/12/0", rsp_valid, rsp_result, rsp_bcond); end
    n_checks++; if (alu_op !== 4'hF) begin n_fail++; $display("FAIL single_alu_park: got %h want f", alu_op); end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    #1;
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_done: got busy %b v %b want 0/00", busy, rsp_valid); end
  endtask

  task automatic test_branch();
    logic [3:0]   ops[2] = '{4'b1000, 4'b1011};
    logic [W-1:0] as[2]  = '{32'd3, 32'd9};
    logic [W-1:0] bs[2]  = '{32'd9, 32'd9};
    logic [W-1:0] rs[2]  = '{32'h0000000A, 32'h0};
    for (int t = 0; t < 2; t++) begin
      set_req(1, ops[t], as[t], bs[t]);
      req_valid = 2'b10;
      #1;
      n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL branch_ready%0d: got %b want 10", t, req_ready); end
      step();
      req_valid = 2'b00;
      step();
      n_checks++; if (rsp_valid !== 2'b10 || rsp_result !== rs[t] || rsp_bcond !== 1'b1) begin
        n_fail++; $display("FAIL branch_rsp%0d: got v %b r %h bc %b want 10/%h/1", t, rsp_valid, rsp_result, rsp_bcond, rs[t]); end
      rsp_ready = 2'b10;
      step();
      rsp_ready = 2'b00;
    end
  endtask

  task automatic test_contention();
    logic [W:0] e;
    rand_req(0); rand_req(1);
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      int g;
      g = k % 2;
      #1;
      n_checks++; if (req_ready !== 2'(1 << g)) begin n_fail++; $display("FAIL contention_grant%0d: got %b want %b", k, req_ready, 2'(1 << g)); end
      exp_q.push_back(alu_ref(req_op[4*g +: 4], req_a[W*g +: W], req_b[W*g +: W]));
      step();
      rand_req(g);
      #1;
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL contention_hold%0d: got %b want 00", k, req_ready); end
      step();
      e = exp_q.pop_front();
      n_checks++; if (rsp_valid !== 2'(1 << g) || {rsp_bcond, rsp_result} !== e) begin
        n_fail++; $display("FAIL contention_rsp%0d: got v %b %b/%h want %b %b/%h", k, rsp_valid, rsp_bcond, rsp_result, 2'(1 << g), e[W], e[W-1:0]); end
      if (k == 3) req_valid = 2'b00;
      step();
    end
    rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure();
    logic [W:0] e;
    rand_req(1);
    req_valid = 2'b10; rsp_ready = 2'b00;
    e = alu_ref(req_op[7:4], req_a[2*W-1:W], req_b[2*W-1:W]);
    step();
    set_req(0, 4'b0101, 32'h00F0, 32'h0F00);
    req_valid = 2'b01; rsp_ready = 2'b01;  // non-owner ready must be ignored
    step();
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (rsp_valid !== 2'b10 || {rsp_bcond, rsp_result} !== e || req_ready !== 2'b00) begin
        n_fail++; $display("FAIL backpressure_hold%0d: got v %b %b/%h ready %b want 10 %b/%h 00", c, rsp_valid, rsp_bcond, rsp_result, req_ready, e[W], e[W-1:0]); end
      step();
    end
    rsp_ready = 2'b11;
    #1;
    n_checks++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL backpressure_release: got %b want 10", rsp_valid); end
    step();
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL backpressure_next_grant: got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    step();
    n_checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'h0FF0 || rsp_bcond !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_rsp0: got v %b %h/%b want 01 00000ff0/0", rsp_valid, rsp_result, rsp_bcond); end
    step();
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_exec();
    set_req(0, 4'b0000, 32'd1, 32'd2);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    #1;
    n_checks++; if (busy !== 1'b1 || alu_op !== 4'b0000) begin n_fail++; $display("FAIL rstexec_in_exec: got busy %b op %h want 1/0", busy, alu_op); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || alu_op !== 4'hF || rsp_result !== '0) begin
      n_fail++; $display("FAIL rstexec_after: got busy %b v %b op %h r %h want 0/00/f/0", busy, rsp_valid, alu_op, rsp_result); end
    set_req(1, 4'b0010, 32'hDEAD, 32'd0);
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstexec_priority: got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    step();
    n_checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd3) begin n_fail++; $display("FAIL rstexec_rsp: got v %b r %0d want 01/3", rsp_valid, rsp_result); end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
  endtask

  task automatic test_shift();
    logic [3:0]   ops[2] = '{4'b1101, 4'b1111};
    logic [W-1:0] rs[2]  = '{32'hC0000008, 32'h0};
    for (int t = 0; t < 2; t++) begin
      set_req(0, ops[t], 32'h80000010, 32'h12345678);
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      step();
      n_checks++; if (rsp_valid !== 2'b01 || rsp_result !== rs[t] || rsp_bcond !== 1'b0) begin
        n_fail++; $display("FAIL shift_rsp%0d: got v %b r %h bc %b want 01/%h/0", t, rsp_valid, rsp_result, rsp_bcond, rs[t]); end
      rsp_ready = 2'b01;
      step();
      rsp_ready = 2'b00;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      int g;
      logic [NREQ-1:0] ev;
      req_valid = NREQ'($urandom_range(0, 3));
      rsp_ready = NREQ'($urandom_range(0, 3));
      rand_req(0); rand_req(1);
      reset = ($urandom_range(0, 49) == 0);
      #1;
      g  = ref_grant();
      ev = (ref_phase == 2) ? NREQ'(1 << ref_owner) : '0;
      n_checks++; if (req_ready !== ((g >= 0) ? NREQ'(1 << g) : NREQ'(0))) begin
        n_fail++; $display("FAIL random_ready c%0d: got %b want grant %0d", c, req_ready, g); end
      n_checks++; if (busy !== (ref_phase != 0)) begin n_fail++; $display("FAIL random_busy c%0d: got %b want %b", c, busy, ref_phase != 0); end
      n_checks++; if (rsp_valid !== ev) begin n_fail++; $display("FAIL random_rsp_valid c%0d: got %b want %b", c, rsp_valid, ev); end
      if (ref_phase == 2) begin
        n_checks++; if (rsp_result !== ref_res || rsp_bcond !== ref_bc) begin
          n_fail++; $display("FAIL random_rsp_data c%0d: got %h/%b want %h/%b", c, rsp_result, rsp_bcond, ref_res, ref_bc); end
      end
      if (ref_phase == 1) begin
        n_checks++; if (alu_op !== ref_op || alu_in_1 !== ref_a || alu_in_2 !== ref_b) begin
          n_fail++; $display("FAIL random_alu c%0d: got %h %h %h want %h %h %h", c, alu_op, alu_in_1, alu_in_2, ref_op, ref_a, ref_b); end
      end else begin
        n_checks++; if (alu_op !== 4'hF || alu_in_1 !== '0 || alu_in_2 !== '0) begin
          n_fail++; $display("FAIL random_alu_park c%0d: got %h %h %h want f 0 0", c, alu_op, alu_in_1, alu_in_2); end
      end
      step();
    end
    reset = 1'b0; req_valid = '0; rsp_ready = '0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single();
    test_branch();
    test_contention();
    test_backpressure();
    test_reset_exec();
    test_shift();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
